// File: rtl/bram_port_master_pkg.sv
// Shared types and default sizes for the BRAM port master
// and the dual-port RAM it drives.
package bram_port_master_pkg;

   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_ADDRESS_WIDTH = 8;
   localparam int DEF_LEN_WIDTH     = 4;
   localparam int DEF_RD_LATENCY    = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/bram_port_master_rd_tag.sv
// Valid-tag shift register that follows issued reads
// through the RAM read latency.
module bram_rd_tag_pipe #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic issue,
   output logic tag_out,
   output logic empty
);

   logic [DEPTH-1:0] tags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tags <= '0;
      end else begin
         tags[0] <= issue;
         for (int i = 1; i < DEPTH; i++) begin
            tags[i] <= tags[i-1];
         end
      end
   end

   assign tag_out = tags[DEPTH-1];
   // an access visible on the pins is still in flight
   assign empty   = ~issue & ~(|tags);

endmodule

// File: rtl/bram_port_master.sv
// Command-driven burst initiator for one port of the
// synchronous dual-port BRAM.
module bram_port_master
   import bram_port_master_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
   parameter int RD_LATENCY    = DEF_RD_LATENCY
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]     cmd_len,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     rd_valid,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     busy,
   output logic                     done,
   output logic                     ram_cs,
   output logic                     ram_oe,
   output logic                     ram_we,
   output logic [ADDRESS_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0]    ram_din,
   input  logic [DATA_WIDTH-1:0]    ram_dout
);

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]     cnt_q;
   logic                     issue;
   logic                     tag_out;
   logic                     tag_empty;

   assign issue     = ram_cs & ram_oe;
   assign cmd_ready = (state == ST_IDLE);
   assign wr_ready  = (state == ST_WRITE);
   assign done      = (state == ST_DONE);
   assign busy      = (state == ST_WRITE)
                    | (state == ST_READ)
                    | (state == ST_DRAIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         ram_cs      <= 1'b0;
         ram_oe      <= 1'b0;
         ram_we      <= 1'b0;
         ram_address <= '0;
         ram_din     <= '0;
      end else begin
         ram_cs <= 1'b0;
         ram_oe <= 1'b0;
         ram_we <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  addr_q <= cmd_addr;
                  cnt_q  <= cmd_len;
                  state  <= cmd_write ? ST_WRITE : ST_READ;
               end
            end
            ST_WRITE: begin
               if (wr_valid) begin
                  ram_cs      <= 1'b1;
                  ram_we      <= 1'b1;
                  ram_address <= addr_q;
                  ram_din     <= wr_data;
                  addr_q      <= addr_q + ADDRESS_WIDTH'(1);
                  cnt_q       <= cnt_q - LEN_WIDTH'(1);
                  if (cnt_q == '0) state <= ST_DONE;
               end
            end
            ST_READ: begin
               ram_cs      <= 1'b1;
               ram_oe      <= 1'b1;
               ram_address <= addr_q;
               addr_q      <= addr_q + ADDRESS_WIDTH'(1);
               cnt_q       <= cnt_q - LEN_WIDTH'(1);
               if (cnt_q == '0) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (tag_empty) state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   bram_rd_tag_pipe #(
      .DEPTH (RD_LATENCY)
   ) u_tag (
      .clk     (clk),
      .rst_n   (rst_n),
      .issue   (issue),
      .tag_out (tag_out),
      .empty   (tag_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= tag_out;
         if (tag_out) rd_data <= ram_dout;
      end
   end

endmodule

// File: tb/tb_bram_port_master.sv
// Bench for bram_port_master: unit 0 uses read latency 1,
// unit 1 uses read latency 3, each with its own RAM model.
module tb_bram_port_master;

   typedef struct packed {
      logic        u;
      logic        wr;
      logic [7:0]  a;
      logic [3:0]  len;
      logic [15:0] vpat;
      logic [3:0][7:0] d;
   } vec_t;

   typedef struct packed {
      logic       u;
      logic [7:0] a;
      logic [7:0] d;
   } wexp_t;

   typedef struct packed {
      logic       u;
      logic [7:0] d;
   } rexp_t;

   typedef struct packed {
      logic u;
      int   c;
   } iexp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       cmd_valid [2];
   logic       cmd_ready [2];
   logic       cmd_write [2];
   logic [7:0] cmd_addr  [2];
   logic [3:0] cmd_len   [2];
   logic       wr_valid  [2];
   logic       wr_ready  [2];
   logic [7:0] wr_data   [2];
   logic       rd_valid  [2];
   logic [7:0] rd_data   [2];
   logic       busy      [2];
   logic       done      [2];
   logic       ram_cs    [2];
   logic       ram_oe    [2];
   logic       ram_we    [2];
   logic [7:0] ram_address [2];
   logic [7:0] ram_din   [2];
   logic [7:0] ram_dout  [2];

   int total = 0;
   int bad = 0;
   int cyc = 0;

   wexp_t wq[$];
   rexp_t rq[$];
   iexp_t iq[$];

   int done_cnt [2] = '{0, 0};
   int done_cyc [2] = '{0, 0};
   int acc_cyc  [2] = '{0, 0};
   int rdv_cnt  [2] = '{0, 0};
   int last_rdv [2] = '{0, 0};
   int run_we   [2] = '{0, 0};
   int last_we  [2] = '{0, 0};
   int run_oe   [2] = '{0, 0};
   int last_oe  [2] = '{0, 0};
   logic prev_we [2] = '{1'b0, 1'b0};
   logic prev_oe [2] = '{1'b0, 1'b0};

   int bd [16];

   function automatic void chk(string nm, int got, int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, got, exp);
      end
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_u
      localparam int L = (g == 0) ? 1 : 3;
      logic [7:0] mem [256];
      logic [7:0] rp [3];

      initial begin
         for (int i = 0; i < 256; i++) mem[i] = 8'h00;
         for (int i = 0; i < 3; i++) rp[i] = 8'h00;
      end

      always @(posedge clk) begin
         if (ram_cs[g] && ram_we[g]) mem[ram_address[g]] <= ram_din[g];
         if (ram_cs[g] && ram_oe[g]) rp[0] <= mem[ram_address[g]];
         rp[1] <= rp[0];
         rp[2] <= rp[1];
      end

      assign ram_dout[g] = rp[L-1];

      bram_port_master #(
         .DATA_WIDTH    (8),
         .ADDRESS_WIDTH (8),
         .LEN_WIDTH     (4),
         .RD_LATENCY    (L)
      ) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .cmd_valid   (cmd_valid[g]),
         .cmd_ready   (cmd_ready[g]),
         .cmd_write   (cmd_write[g]),
         .cmd_addr    (cmd_addr[g]),
         .cmd_len     (cmd_len[g]),
         .wr_valid    (wr_valid[g]),
         .wr_ready    (wr_ready[g]),
         .wr_data     (wr_data[g]),
         .rd_valid    (rd_valid[g]),
         .rd_data     (rd_data[g]),
         .busy        (busy[g]),
         .done        (done[g]),
         .ram_cs      (ram_cs[g]),
         .ram_oe      (ram_oe[g]),
         .ram_we      (ram_we[g]),
         .ram_address (ram_address[g]),
         .ram_din     (ram_din[g]),
         .ram_dout    (ram_dout[g])
      );
   end

   always @(posedge clk) cyc++;

   // scoreboard side: pops expectations as the DUTs produce activity
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (ram_we[u]) begin
            chk($sformatf("u%0d write expected", u), int'(wq.size() != 0), 1);
            chk($sformatf("u%0d we with cs", u), ram_cs[u], 1);
            chk($sformatf("u%0d we without oe", u), ram_oe[u], 0);
            if (wq.size() != 0) begin
               wexp_t e;
               e = wq.pop_front();
               chk($sformatf("u%0d write unit", u), u, e.u);
               chk($sformatf("u%0d write addr", u), ram_address[u], e.a);
               chk($sformatf("u%0d write din", u), ram_din[u], e.d);
            end
            if (!prev_we[u]) run_we[u] = cyc;
            last_we[u] = cyc;
         end
         prev_we[u] = ram_we[u];
         if (ram_cs[u] && ram_oe[u]) begin
            iexp_t ie;
            ie.u = u[0];
            ie.c = cyc;
            iq.push_back(ie);
            if (!prev_oe[u]) run_oe[u] = cyc;
            last_oe[u] = cyc;
         end
         prev_oe[u] = ram_cs[u] && ram_oe[u];
         if (rd_valid[u]) begin
            rdv_cnt[u]++;
            last_rdv[u] = cyc;
            chk($sformatf("u%0d read expected", u), int'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
               rexp_t r;
               r = rq.pop_front();
               chk($sformatf("u%0d read unit", u), u, r.u);
               chk($sformatf("u%0d rd_data", u), rd_data[u], r.d);
            end
            if (iq.size() != 0) begin
               iexp_t ie;
               ie = iq.pop_front();
               chk($sformatf("u%0d rd latency", u),
                   cyc - ie.c, (u == 0) ? 2 : 4);
            end
         end
         if (done[u]) begin
            done_cnt[u]++;
            done_cyc[u] = cyc;
         end
         if (cmd_valid[u] && cmd_ready[u]) acc_cyc[u] = cyc;
      end
   end

   task automatic do_burst(input int u, input bit wr, input int addr,
                           input int len, input logic [15:0] vpat);
      int n;
      int p;
      int beats;
      int d0;
      d0 = done_cnt[u];
      if (!wr) begin
         for (int k = 0; k <= len; k++) begin
            rexp_t r;
            r.u = u[0];
            r.d = 8'(bd[k]);
            rq.push_back(r);
         end
      end
      @(posedge clk); #1;
      cmd_valid[u] = 1'b1;
      cmd_write[u] = wr;
      cmd_addr[u]  = 8'(addr);
      cmd_len[u]   = 4'(len);
      n = 0;
      while (!cmd_ready[u] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      cmd_valid[u] = 1'b0;
      chk($sformatf("u%0d busy after accept", u), busy[u], 1);
      chk($sformatf("u%0d not ready in burst", u), cmd_ready[u], 0);
      p = 0;
      beats = 0;
      n = 0;
      while (wr && beats <= len && n < 100) begin
         wr_valid[u] = vpat[p % 16];
         wr_data[u]  = 8'(bd[beats]);
         @(negedge clk);
         if (wr_valid[u] && wr_ready[u]) begin
            wexp_t e;
            e.u = u[0];
            e.a = 8'(addr + beats);
            e.d = 8'(bd[beats]);
            wq.push_back(e);
            beats++;
         end
         @(posedge clk); #1;
         p++;
         n++;
      end
      wr_valid[u] = 1'b0;
      n = 0;
      while (done_cnt[u] == d0 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      @(negedge clk); #1;
      chk($sformatf("u%0d done once", u), done_cnt[u] - d0, 1);
      chk($sformatf("u%0d busy after", u), busy[u], 0);
      chk($sformatf("u%0d done low after", u), done[u], 0);
      chk($sformatf("u%0d cmd_ready after", u), cmd_ready[u], 1);
      chk($sformatf("u%0d writes left", u), wq.size(), 0);
      chk($sformatf("u%0d reads left", u), rq.size(), 0);
      if (wr && vpat == 16'hFFFF)
         chk($sformatf("u%0d we run", u), last_we[u] - run_we[u], len);
      if (!wr) begin
         chk($sformatf("u%0d oe run", u), last_oe[u] - run_oe[u], len);
         chk($sformatf("u%0d done after rdv", u),
             done_cyc[u] - last_rdv[u], 1);
      end
   endtask

   function automatic vec_t mk(logic u, logic wr, logic [7:0] a,
                               logic [3:0] len, logic [15:0] vpat,
                               logic [7:0] d0, logic [7:0] d1,
                               logic [7:0] d2, logic [7:0] d3);
      vec_t v;
      v.u = u;
      v.wr = wr;
      v.a = a;
      v.len = len;
      v.vpat = vpat;
      v.d[0] = d0;
      v.d[1] = d1;
      v.d[2] = d2;
      v.d[3] = d3;
      return v;
   endfunction

   vec_t vt [8];

   initial begin
      int n;
      int d0;
      int r0;
      int dc;
      for (int u = 0; u < 2; u++) begin
         cmd_valid[u] = 1'b0;
         cmd_write[u] = 1'b0;
         cmd_addr[u]  = 8'h00;
         cmd_len[u]   = 4'h0;
         wr_valid[u]  = 1'b0;
         wr_data[u]   = 8'h00;
      end
      vt[0] = mk(0, 1, 8'd0,   4'd2, 16'hFFFF, 145, 155, 165, 0);
      vt[1] = mk(0, 0, 8'd0,   4'd2, 16'hFFFF, 145, 155, 165, 0);
      vt[2] = mk(0, 1, 8'd254, 4'd3, 16'hFFED, 1, 2, 3, 4);
      vt[3] = mk(0, 0, 8'd254, 4'd3, 16'hFFFF, 1, 2, 3, 4);
      vt[4] = mk(0, 0, 8'd0,   4'd1, 16'hFFFF, 3, 4, 0, 0);
      vt[5] = mk(1, 1, 8'd0,   4'd2, 16'hFFFF, 145, 155, 165, 0);
      vt[6] = mk(1, 0, 8'd0,   4'd2, 16'hFFFF, 145, 155, 165, 0);
      vt[7] = mk(1, 0, 8'd2,   4'd0, 16'hFFFF, 165, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d reset cmd_ready", u), cmd_ready[u], 1);
         chk($sformatf("u%0d reset busy", u), busy[u], 0);
         chk($sformatf("u%0d reset done", u), done[u], 0);
         chk($sformatf("u%0d reset wr_ready", u), wr_ready[u], 0);
         chk($sformatf("u%0d reset rd_valid", u), rd_valid[u], 0);
         chk($sformatf("u%0d reset cs", u), ram_cs[u], 0);
         chk($sformatf("u%0d reset we", u), ram_we[u], 0);
         chk($sformatf("u%0d reset oe", u), ram_oe[u], 0);
         chk($sformatf("u%0d reset addr", u), ram_address[u], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 4; k++) bd[k] = vt[i].d[k];
         do_burst(vt[i].u, vt[i].wr, vt[i].a, vt[i].len, vt[i].vpat);
      end

      // full 16-word burst and read back
      for (int k = 0; k < 16; k++) bd[k] = 100 + k;
      do_burst(0, 1, 8'h80, 15, 16'hFFFF);
      do_burst(0, 0, 8'h80, 15, 16'hFFFF);

      // reset while the second beat of a 4-word write is on the pins
      begin
         wexp_t e;
         @(posedge clk); #1;
         cmd_valid[0] = 1'b1;
         cmd_write[0] = 1'b1;
         cmd_addr[0]  = 8'h40;
         cmd_len[0]   = 4'd3;
         wr_valid[0]  = 1'b1;
         wr_data[0]   = 8'd11;
         e.u = 1'b0; e.a = 8'h40; e.d = 8'd11;
         wq.push_back(e);
         e.u = 1'b0; e.a = 8'h41; e.d = 8'd22;
         wq.push_back(e);
         @(posedge clk); #1;
         cmd_valid[0] = 1'b0;
         @(posedge clk); #1;
         wr_data[0] = 8'd22;
         @(posedge clk); #1;
         wr_data[0] = 8'd33;
         chk("mid-reset beat2 addr", ram_address[0], 8'h41);
         @(negedge clk); #2;
         rst_n = 1'b0;
         #1;
         chk("async rst we", ram_we[0], 0);
         chk("async rst cs", ram_cs[0], 0);
         chk("async rst cmd_ready", cmd_ready[0], 1);
         chk("async rst busy", busy[0], 0);
         chk("async rst wr_ready", wr_ready[0], 0);
         @(posedge clk); #1;
         rst_n = 1'b1;
         wr_valid[0] = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         chk("post-reset writes left", wq.size(), 0);
         chk("post-reset idle", cmd_ready[0], 1);
      end
      bd[0] = 11;
      do_burst(0, 0, 8'h40, 0, 16'hFFFF);
      bd[0] = 0;
      do_burst(0, 0, 8'h42, 0, 16'hFFFF);

      // read queued with cmd_valid held during a write burst
      begin
         wexp_t e;
         rexp_t r;
         d0 = done_cnt[0];
         r0 = rdv_cnt[0];
         @(posedge clk); #1;
         cmd_valid[0] = 1'b1;
         cmd_write[0] = 1'b1;
         cmd_addr[0]  = 8'h10;
         cmd_len[0]   = 4'd1;
         wr_valid[0]  = 1'b1;
         wr_data[0]   = 8'd7;
         @(posedge clk); #1;
         cmd_write[0] = 1'b0;
         cmd_len[0]   = 4'd0;
         e.u = 1'b0; e.a = 8'h10; e.d = 8'd7;
         wq.push_back(e);
         e.u = 1'b0; e.a = 8'h11; e.d = 8'd8;
         wq.push_back(e);
         r.u = 1'b0; r.d = 8'd7;
         rq.push_back(r);
         @(posedge clk); #1;
         wr_data[0] = 8'd8;
         @(posedge clk); #1;
         wr_valid[0] = 1'b0;
         n = 0;
         while (done_cnt[0] == d0 && n < 20) begin
            @(negedge clk); #1;
            n++;
         end
         chk("b2b write done", done_cnt[0] - d0, 1);
         dc = done_cyc[0];
         @(posedge clk); #1;
         @(negedge clk); #1;
         chk("b2b accept after done", acc_cyc[0] - dc, 1);
         @(posedge clk); #1;
         cmd_valid[0] = 1'b0;
         n = 0;
         while (done_cnt[0] == d0 + 1 && n < 20) begin
            @(negedge clk); #1;
            n++;
         end
         repeat (3) @(negedge clk);
         #1;
         chk("b2b read done", done_cnt[0] - d0, 2);
         chk("b2b one rd_valid", rdv_cnt[0] - r0, 1);
         chk("b2b reads left", rq.size(), 0);
         chk("b2b idle", cmd_ready[0], 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bram_port_master.md
Name: bram_port_master

Overview:
- Initiator that drives one port of the team's synchronous dual-port BRAM through its cs/oe/we/address/din/dout pins.
- Turns a command handshake (start address, burst length, direction) into correctly timed RAM cycles.
- Write data comes in on a valid/ready stream; read data goes out on a valid-only stream.
- One instance per RAM port; the two ports run independent masters.

Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDRESS_WIDTH, 8, RAM address width; depth = 2**ADDRESS_WIDTH
- LEN_WIDTH, 4, burst length field; burst = cmd_len+1 words (1..16)
- RD_LATENCY, 1, RAM cycles from registered address to valid ram_dout (legal 1..3)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDRESS_WIDTH  burst start address
- cmd_len  in  LEN_WIDTH  words minus one
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted
- wr_data  in  DATA_WIDTH  write word
- rd_valid  out  1  read word valid (no backpressure)
- rd_data  out  DATA_WIDTH  read word
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- ram_cs  out  1  RAM chip select
- ram_oe  out  1  RAM output enable
- ram_we  out  1  RAM write enable
- ram_address  out  ADDRESS_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0 except cmd_ready=1. Internal address/count/pipeline cleared. Any burst in flight is abandoned; no further RAM cycle is issued.
- All ram_* outputs are registered. A RAM access is "issued" in the cycle its registered values are visible.
- cmd_ready = (state==IDLE). Command is captured on cmd_valid&cmd_ready: addr_q=cmd_addr, cnt_q=cmd_len, dir_q=cmd_write. busy goes high the next cycle.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE -> WRITE on accepted command with cmd_write=1; IDLE -> READ on accepted command with cmd_write=0.
- WRITE:
  - wr_ready=1.
  - On wr_valid, the next cycle drives ram_cs=1, ram_we=1, ram_oe=0, ram_address=addr_q, ram_din=wr_data.
  - addr_q increments; cnt_q decrements.
  - A cycle without wr_valid issues no access: ram_cs=0, ram_we=0.
  - After the beat with cnt_q==0, go to DONE and drop wr_ready the same edge.
- READ:
  - Issue one access per cycle, no gaps: ram_cs=1, ram_oe=1, ram_we=0, ram_address=addr_q.
  - addr_q increments.
  - After cnt_q==0 is issued, go to DRAIN.
- Read return:
  - A valid-tag shift register of depth RD_LATENCY tracks issued reads.
  - rd_data is registered from ram_dout. rd_valid asserts RD_LATENCY+1 cycles after the access is issued, one pulse per word, in address order.
- DRAIN: ram_cs=0, ram_oe=0. Wait until the tag pipe is empty, then go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- No new command is accepted until IDLE. The next burst can be accepted in the cycle after done.
- Address arithmetic: modulo 2**ADDRESS_WIDTH, so 255 wraps to 0 with no error.
- Burst length: cmd_len=0 gives exactly one word; cmd_len all-ones gives 2**LEN_WIDTH words.
- Idle RAM pins: cs=we=oe=0. ram_address and ram_din hold their last value.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, WRITE, READ, DRAIN, DONE);
  - default width constants (DATA_WIDTH=8, ADDRESS_WIDTH=8) shared with the dual-port RAM;
  - the RAM read latency constant.
- One sub-module, bram_rd_tag_pipe: RD_LATENCY-deep valid shift register with an "empty" output, used for the rd_valid timing and the DRAIN exit condition.

Test Plan:
- Write cmd addr=0 len=2, data 145,155,165 with wr_valid continuous -> ram_we high 3 consecutive cycles at addresses 0,1,2 with din 145,155,165; one done pulse; busy low after.
- Read cmd addr=0 len=2 after the previous test, RD_LATENCY=1 -> ram_oe high 3 cycles; rd_valid pulses 2 cycles after each issue; rd_data 145,155,165 in order; done only after the third word.
- Write cmd addr=254 len=3, data 1..4, wr_valid toggled 1,0,1,1,0,1 -> accesses only on valid cycles at addresses 254,255,0,1; no ram_we in gap cycles; read-back returns 1,2,3,4.
- Deassert rst_n for half a cycle during the second beat of a 4-word write -> outputs cleared immediately; cmd_ready=1; no further ram_we; address 2 of the burst is not written.
- Back-to-back commands: read len=0 queued with cmd_valid held during a write burst -> accepted in the cycle after done; exactly one rd_valid.
- Repeat the read test with RD_LATENCY=3 -> rd_valid 4 cycles after each issue; DRAIN lasts until the last word; done follows the last rd_valid by one cycle.
